// File: rtl/dac_pattern_burst.sv
// dac_pattern_burst
//   Plays a _PAT_WIDTH-bit pattern MSB-first as a two-level DAC code stream
//   (amp_high for a 1 bit, amp_low for a 0 bit). The pattern is repeated as
//   bursts separated by programmable idle gaps. Single 50 MHz fabric domain.
//
// Ports
//   sys_clk        clock
//   sys_rst_n      synchronous active-low reset
//   pwm_en         run enable: rising edge in IDLE starts, low level aborts
//   duty_num       clocks per pattern bit (0 treated as 1)
//   pulse_dessert  idle clocks between bursts (0 = back-to-back)
//   pulse_num      burst count (0 = run forever)
//   PAT            pattern, MSB played first
//   amp_high       DAC code for a 1 bit
//   amp_low        DAC code for a 0 bit and for gaps
//   dac_data       registered DAC code (mid-scale when idle)
//   pwm_out        registered current pattern bit (0 in gaps / idle)
//   busy           high from LOAD through the end of the last burst
//   valid          one-clock pulse on normal completion
module dac_pattern_burst #(
  parameter int _PAT_WIDTH = 32,
  parameter int _DAC_WIDTH = 8
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   pwm_en,
  input  logic [7:0]             duty_num,
  input  logic [16:0]            pulse_dessert,
  input  logic [7:0]             pulse_num,
  input  logic [_PAT_WIDTH-1:0]  PAT,
  input  logic [_DAC_WIDTH-1:0]  amp_high,
  input  logic [_DAC_WIDTH-1:0]  amp_low,
  output logic [_DAC_WIDTH-1:0]  dac_data,
  output logic                   pwm_out,
  output logic                   busy,
  output logic                   valid
);

  localparam int BW = (_PAT_WIDTH > 1) ? $clog2(_PAT_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(_PAT_WIDTH - 1);
  localparam logic [_DAC_WIDTH-1:0] MID = {1'b1, {(_DAC_WIDTH-1){1'b0}}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state;
  logic                  pwm_en_d;

  // shadow copies of the configuration, frozen at LOAD
  logic [7:0]            duty_s;
  logic [16:0]           dess_s;
  logic [7:0]            pnum_s;
  logic [_PAT_WIDTH-1:0] pat_s;
  logic [_DAC_WIDTH-1:0] ah_s;
  logic [_DAC_WIDTH-1:0] al_s;

  logic [BW-1:0]         bit_cnt;
  logic [7:0]            dur_cnt;
  logic [7:0]            burst_cnt;
  logic [16:0]           gap_cnt;

  logic                  cur_bit;
  logic                  start;
  logic                  abort;
  logic                  bit_end;
  logic                  burst_end;
  logic                  last_burst;

  assign cur_bit    = pat_s[LAST_BIT - bit_cnt];
  assign start      = (state == S_IDLE) && pwm_en && !pwm_en_d;
  assign abort      = !pwm_en && ((state == S_LOAD) || (state == S_SHIFT) || (state == S_GAP));
  assign bit_end    = (dur_cnt == duty_s - 8'd1);
  assign burst_end  = bit_end && (bit_cnt == LAST_BIT);
  // burst_cnt still holds the pre-increment value on the completing clock
  assign last_burst = (pnum_s != 8'd0) && (burst_cnt + 8'd1 == pnum_s);

  // Outputs are registered from the state held during the clock, so they lag
  // the state by one edge: LOAD shows mid-scale with busy up, and the first
  // pattern bit appears one edge after LOAD.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state     <= S_IDLE;
      pwm_en_d  <= 1'b0;
      duty_s    <= '0;
      dess_s    <= '0;
      pnum_s    <= '0;
      pat_s     <= '0;
      ah_s      <= '0;
      al_s      <= '0;
      bit_cnt   <= '0;
      dur_cnt   <= '0;
      burst_cnt <= '0;
      gap_cnt   <= '0;
      dac_data  <= MID;
      pwm_out   <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
    end else begin
      pwm_en_d <= pwm_en;
      valid    <= 1'b0;
      if (abort) begin
        // abort wins over any burst-end transition in the same clock
        state    <= S_IDLE;
        dac_data <= MID;
        pwm_out  <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            dac_data <= MID;
            pwm_out  <= 1'b0;
            busy     <= 1'b0;
            if (start) state <= S_LOAD;
          end
          S_LOAD: begin
            duty_s    <= (duty_num == 8'd0) ? 8'd1 : duty_num;
            dess_s    <= pulse_dessert;
            pnum_s    <= pulse_num;
            pat_s     <= PAT;
            ah_s      <= amp_high;
            al_s      <= amp_low;
            bit_cnt   <= '0;
            dur_cnt   <= '0;
            burst_cnt <= '0;
            gap_cnt   <= '0;
            dac_data  <= MID;
            pwm_out   <= 1'b0;
            busy      <= 1'b1;
            state     <= S_SHIFT;
          end
          S_SHIFT: begin
            dac_data <= cur_bit ? ah_s : al_s;
            pwm_out  <= cur_bit;
            if (!bit_end) begin
              dur_cnt <= dur_cnt + 8'd1;
            end else begin
              dur_cnt <= '0;
              if (!burst_end) begin
                bit_cnt <= bit_cnt + BW'(1);
              end else begin
                bit_cnt   <= '0;
                burst_cnt <= burst_cnt + 8'd1;   // wraps 255 -> 0 when infinite
                if (last_burst) begin
                  state <= S_DONE;
                end else if (dess_s != 17'd0) begin
                  gap_cnt <= '0;
                  state   <= S_GAP;
                end
              end
            end
          end
          S_GAP: begin
            dac_data <= al_s;
            pwm_out  <= 1'b0;
            if (gap_cnt == dess_s - 17'd1) begin
              gap_cnt <= '0;
              state   <= S_SHIFT;
            end else begin
              gap_cnt <= gap_cnt + 17'd1;
            end
          end
          S_DONE: begin
            valid    <= 1'b1;
            busy     <= 1'b0;
            dac_data <= MID;
            pwm_out  <= 1'b0;
            state    <= S_IDLE;
          end
          default: begin
            dac_data <= MID;
            pwm_out  <= 1'b0;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dac_pattern_burst.sv
// Testbench for dac_pattern_burst. Expected per-clock output samples are
// queued when each run is launched; a negedge monitor pops the entries whose
// cycle number has come up and compares them with the DUT outputs.
module tb_dac_pattern_burst;

  localparam int BIG = 32'h3fff_ffff;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        pwm_en = 1'b0;
  logic [7:0]  duty_num = '0;
  logic [16:0] pulse_dessert = '0;
  logic [7:0]  pulse_num = '0;
  logic [31:0] PAT = '0;
  logic [7:0]  amp_high = '0;
  logic [7:0]  amp_low = '0;
  logic [7:0]  dac_data;
  logic        pwm_out;
  logic        busy;
  logic        valid;

  dac_pattern_burst #(._PAT_WIDTH(32), ._DAC_WIDTH(8)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .pwm_en       (pwm_en),
    .duty_num     (duty_num),
    .pulse_dessert(pulse_dessert),
    .pulse_num    (pulse_num),
    .PAT          (PAT),
    .amp_high     (amp_high),
    .amp_low      (amp_low),
    .dac_data     (dac_data),
    .pwm_out      (pwm_out),
    .busy         (busy),
    .valid        (valid)
  );

  always #10 sys_clk = ~sys_clk;

  // cyc = number of rising edges seen so far
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    int         id;
    logic [7:0] dac;
    logic       pwm;
    logic       bsy;
    logic       vld;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   tid = 0;

  // Any sample at or after 'cut' (abort or reset edge) is idle.
  function automatic void push(int c, int cut, logic [7:0] d, logic p, logic b, logic v);
    exp_t e;
    e.c = c; e.id = tid;
    if (c >= cut) begin
      e.dac = 8'h80; e.pwm = 1'b0; e.bsy = 1'b0; e.vld = 1'b0;
    end else begin
      e.dac = d; e.pwm = p; e.bsy = b; e.vld = v;
    end
    q.push_back(e);
  endfunction

  // Expected trace for a run whose start is detected at edge e0.
  // Returns the first cycle after the queued trace.
  function automatic int push_run(int e0, logic [31:0] pat, int duty, int nb, int dess,
                                  logic [7:0] ah, logic [7:0] al, bit done, int cut);
    int t;
    int d;
    d = (duty == 0) ? 1 : duty;
    push(e0,     cut, 8'h80, 1'b0, 1'b0, 1'b0);   // still idle on the detecting edge
    push(e0 + 1, cut, 8'h80, 1'b0, 1'b1, 1'b0);   // LOAD: busy up, mid-scale
    t = e0 + 2;
    for (int b = 0; b < nb; b++) begin
      for (int i = 31; i >= 0; i--)
        for (int k = 0; k < d; k++) begin
          push(t, cut, pat[i] ? ah : al, pat[i], 1'b1, 1'b0);
          t++;
        end
      if (b != nb - 1 || !done)
        for (int k = 0; k < dess; k++) begin
          push(t, cut, al, 1'b0, 1'b1, 1'b0);
          t++;
        end
    end
    if (done) begin
      push(t, cut, 8'h80, 1'b0, 1'b0, 1'b1); t++;
      push(t, cut, 8'h80, 1'b0, 1'b0, 1'b0); t++;
    end
    return t;
  endfunction

  // monitor / scoreboard
  always @(negedge sys_clk) begin
    while (q.size() > 0 && q[0].c <= cyc) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if (e.c != cyc || dac_data !== e.dac || pwm_out !== e.pwm ||
          busy !== e.bsy || valid !== e.vld) begin
        fails++;
        $display("FAIL test%0d cyc%0d: got dac=%h pwm=%b busy=%b valid=%b, need dac=%h pwm=%b busy=%b valid=%b (sample cyc%0d)",
                 e.id, cyc, dac_data, pwm_out, busy, valid, e.dac, e.pwm, e.bsy, e.vld, e.c);
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 20000) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    if (q.size() > 0) begin
      $display("FAIL drain test%0d: %0d samples left, need 0", tid, q.size());
      $fatal(1, "scoreboard stuck");
    end
  endtask

  // kind: 0 = run to completion, 1 = drop pwm_en so it is sampled low at
  // edge e0+cut_off, 2 = synchronous reset at edge e0+cut_off.
  task automatic run(input int id, input logic [31:0] pat, input int duty, input int nb,
                     input int dess, input int pnum, input logic [7:0] ah,
                     input logic [7:0] al, input bit done, input int kind,
                     input int cut_off);
    int e0;
    int cut;
    int endc;
    tid           = id;
    PAT           = pat;
    duty_num      = 8'(duty);
    pulse_dessert = 17'(dess);
    pulse_num     = 8'(pnum);
    amp_high      = ah;
    amp_low       = al;
    e0   = cyc + 1;
    cut  = (kind == 0) ? BIG : e0 + cut_off;
    endc = push_run(e0, pat, duty, nb, dess, ah, al, done, cut);
    pwm_en = 1'b1;
    if (kind == 1) begin
      wait_cyc(cut - 1);
      pwm_en = 1'b0;
    end else if (kind == 2) begin
      wait_cyc(cut - 1);
      sys_rst_n = 1'b0;
      pwm_en    = 1'b0;
      wait_cyc(cut);
      sys_rst_n = 1'b1;
    end
    drain();
    pwm_en = 1'b0;
    wait_cyc(cyc + 2);
    if (endc < 0) $display("unexpected trace end");
  endtask

  initial begin
    int e0;
    int endc;

    // reset values, then idle with pwm_en low
    tid = 1;
    for (int c = 1; c <= 5; c++) push(c, BIG, 8'h80, 1'b0, 1'b0, 1'b0);
    wait_cyc(3);
    sys_rst_n = 1'b1;
    drain();

    // single burst; inputs changed mid-burst must not matter; pwm_en stays
    // high through DONE and must not retrigger
    tid = 2;
    PAT = 32'hA000_0000; duty_num = 8'd2; pulse_num = 8'd1; pulse_dessert = 17'd0;
    amp_high = 8'hFF; amp_low = 8'h00;
    e0   = cyc + 1;
    endc = push_run(e0, 32'hA000_0000, 2, 1, 0, 8'hFF, 8'h00, 1'b1, BIG);
    for (int c = endc; c < endc + 10; c++) push(c, BIG, 8'h80, 1'b0, 1'b0, 1'b0);
    pwm_en = 1'b1;
    wait_cyc(e0 + 10);
    PAT = 32'h0F0F_0F0F; amp_high = 8'h11; duty_num = 8'd3;
    drain();
    pwm_en = 1'b0;
    wait_cyc(cyc + 1);

    // re-armed start picks up the new values
    tid = 3;
    e0 = cyc + 1;
    endc = push_run(e0, 32'h0F0F_0F0F, 3, 1, 0, 8'h11, 8'h00, 1'b1, BIG);
    pwm_en = 1'b1;
    drain();
    pwm_en = 1'b0;
    wait_cyc(cyc + 2);

    // multi-burst with gaps (busy 107 clocks)
    run(4, 32'hFFFF_FFFF, 1, 3, 5, 3, 8'hC0, 8'h10, 1'b1, 0, 0);
    // duty 0 -> 1, back-to-back bursts
    run(5, 32'h0000_0001, 0, 2, 0, 2, 8'hFF, 8'h00, 1'b1, 0, 0);
    // infinite: 300 bursts (burst_cnt wraps), abort mid 300th burst
    run(6, 32'hC300_0081, 1, 300, 1, 0, 8'hAA, 8'h55, 1'b0, 1, 2 + 299 * 33 + 10);
    // abort on the clock that would end the final burst
    run(7, 32'h8000_0001, 1, 1, 0, 1, 8'h77, 8'h22, 1'b1, 1, 33);
    // abort while in LOAD
    run(8, 32'hFFFF_FFFF, 1, 1, 0, 1, 8'h77, 8'h22, 1'b1, 1, 1);
    // reset mid-gap, then a normal run
    run(9, 32'hF000_000F, 1, 2, 10, 2, 8'hEE, 8'h01, 1'b1, 2, 38);
    run(10, 32'h1234_5678, 4, 2, 3, 2, 8'h9C, 8'h63, 1'b1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "timeout");
  end

endmodule
